// File: rtl/multu_seq_if.sv
// Start/busy handshake and result bus shared by the HI/LO unit's iterative multiplier and divider.
interface multu_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output a, b, start, input busy, done, hi, lo);
    modport slave  (input a, b, start, output busy, done, hi, lo);
endinterface

// File: rtl/multu_seq.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH radix-2 shift-add multiplier (MULTU).
module multu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic        clock,
    input  logic        resetn,
    multu_seq_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic               done_q, done_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [WIDTH-1:0]   reg_b, reg_b_n;
    logic [WIDTH-1:0]   reg_hi, reg_hi_n;
    logic [WIDTH-1:0]   reg_lo, reg_lo_n;
    logic [WIDTH:0]     sum;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            done_q <= 1'b0;
            count  <= '0;
            reg_b  <= '0;
            reg_hi <= '0;
            reg_lo <= '0;
        end else begin
            state  <= state_n;
            done_q <= done_n;
            count  <= count_n;
            reg_b  <= reg_b_n;
            reg_hi <= reg_hi_n;
            reg_lo <= reg_lo_n;
        end
    end

    // Extra top bit keeps the carry of the partial-product add.
    assign sum = {1'b0, reg_hi} + (reg_lo[0] ? {1'b0, reg_b} : '0);

    always_comb begin
        state_n  = state;
        done_n   = 1'b0;
        count_n  = count;
        reg_b_n  = reg_b;
        reg_hi_n = reg_hi;
        reg_lo_n = reg_lo;
        if (bus.start) begin
            // A start while busy aborts the running operation.
            state_n  = RUN;
            count_n  = '0;
            reg_b_n  = bus.b;
            reg_hi_n = '0;
            reg_lo_n = bus.a;
        end else if (state == RUN) begin
            reg_hi_n = sum[WIDTH:1];
            reg_lo_n = {sum[0], reg_lo[WIDTH-1:1]};
            count_n  = count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.hi   = reg_hi;
    assign bus.lo   = reg_lo;
endmodule
